// File: rtl/rtc_calendar_counter.sv
// Calendar clock for 2000-2099. Each level change of sec_toggle advances one second.
// The block also handles a validated synchronous load and emits second, day and century carry pulses.
module rtc_calendar_counter #(
    parameter int unsigned RESET_DAY   = 1,
    parameter int unsigned RESET_MONTH = 1,
    parameter int unsigned RESET_YEAR  = 0
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       sec_toggle,
    input  logic       set_en,
    input  logic [5:0] set_sec,
    input  logic [5:0] set_min,
    input  logic [4:0] set_hour,
    input  logic [4:0] set_day,
    input  logic [3:0] set_month,
    input  logic [6:0] set_year,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic       sec_pulse,
    output logic       day_pulse,
    output logic       century_pulse,
    output logic       set_err
);

    localparam logic [4:0] RST_DAY   = 5'(RESET_DAY);
    localparam logic [3:0] RST_MONTH = 4'(RESET_MONTH);
    localparam logic [6:0] RST_YEAR  = 7'(RESET_YEAR);

    // The divisible-by-4 leap rule is exact across 2000-2099 because 2000 is a leap year.
    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

    logic       toggle_q;
    logic       armed;
    logic       tick;

    logic       c_min, c_hour, c_day, c_month, c_year, c_century;
    logic [5:0] nx_sec, nx_min;
    logic [4:0] nx_hour, nx_day;
    logic [3:0] nx_month;
    logic [6:0] nx_year;
    logic [4:0] dim_cur;
    logic [4:0] dim_set;
    logic       set_valid;

    // A level already present at reset release must not count, hence the armed gate.
    assign tick = armed & (sec_toggle ^ toggle_q);

    assign dim_cur = days_in_month(month, year);
    assign dim_set = days_in_month(set_month, set_year);

    assign set_valid = (set_sec <= 6'd59) && (set_min <= 6'd59) && (set_hour <= 5'd23)
                    && (set_month >= 4'd1) && (set_month <= 4'd12) && (set_year <= 7'd99)
                    && (set_day >= 5'd1) && (set_day <= dim_set);

    assign c_min     = (sec == 6'd59);
    assign c_hour    = c_min & (min == 6'd59);
    assign c_day     = c_hour & (hour == 5'd23);
    assign c_month   = c_day & (day >= dim_cur);
    assign c_year    = c_month & (month == 4'd12);
    assign c_century = c_year & (year == 7'd99);

    always_comb begin
        nx_sec   = c_min ? 6'd0 : sec + 6'd1;
        nx_min   = min;
        nx_hour  = hour;
        nx_day   = day;
        nx_month = month;
        nx_year  = year;
        if (c_min)     nx_min   = c_hour ? 6'd0 : min + 6'd1;
        if (c_hour)    nx_hour  = c_day ? 5'd0 : hour + 5'd1;
        if (c_day)     nx_day   = c_month ? 5'd1 : day + 5'd1;
        if (c_month)   nx_month = c_year ? 4'd1 : month + 4'd1;
        if (c_year)    nx_year  = c_century ? 7'd0 : year + 7'd1;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q      <= 1'b0;
            armed         <= 1'b0;
            sec           <= '0;
            min           <= '0;
            hour          <= '0;
            day           <= RST_DAY;
            month         <= RST_MONTH;
            year          <= RST_YEAR;
            sec_pulse     <= 1'b0;
            day_pulse     <= 1'b0;
            century_pulse <= 1'b0;
            set_err       <= 1'b0;
        end else begin
            toggle_q      <= sec_toggle;
            armed         <= 1'b1;
            sec_pulse     <= 1'b0;
            day_pulse     <= 1'b0;
            century_pulse <= 1'b0;
            set_err       <= 1'b0;
            // A load wins over a coincident tick; that tick is dropped even when the load is rejected.
            if (set_en) begin
                if (set_valid) begin
                    sec   <= set_sec;
                    min   <= set_min;
                    hour  <= set_hour;
                    day   <= set_day;
                    month <= set_month;
                    year  <= set_year;
                end else begin
                    set_err <= 1'b1;
                end
            end else if (tick) begin
                sec           <= nx_sec;
                min           <= nx_min;
                hour          <= nx_hour;
                day           <= nx_day;
                month         <= nx_month;
                year          <= nx_year;
                sec_pulse     <= 1'b1;
                day_pulse     <= c_day;
                century_pulse <= c_century;
            end
        end
    end

endmodule

// File: tb/tb_rtc_calendar_counter.sv
// Bench for rtc_calendar_counter. A seconds-of-day and date model is checked on every falling edge,
// directed scenarios add literal expectations, and random toggles and loads follow.
module tb_rtc_calendar_counter;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       sec_toggle;
    logic       set_en;
    logic [5:0] set_sec, set_min;
    logic [4:0] set_hour, set_day;
    logic [3:0] set_month;
    logic [6:0] set_year;
    logic [5:0] sec, min;
    logic [4:0] hour, day;
    logic [3:0] month;
    logic [6:0] year;
    logic       sec_pulse, day_pulse, century_pulse, set_err;

    int total = 0;
    int bad   = 0;

    rtc_calendar_counter dut (
        .clk_in(clk_in), .rst_n(rst_n), .sec_toggle(sec_toggle), .set_en(set_en),
        .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour), .set_day(set_day),
        .set_month(set_month), .set_year(set_year),
        .sec(sec), .min(min), .hour(hour), .day(day), .month(month), .year(year),
        .sec_pulse(sec_pulse), .day_pulse(day_pulse), .century_pulse(century_pulse),
        .set_err(set_err)
    );

    always #5 clk_in = ~clk_in;

    // Model state: time of day as a plain second count plus the calendar date.
    int m_sod, m_day, m_mon, m_year;
    bit m_sp, m_dp, m_cp, m_err, m_tq, m_armed;
    int dim_tbl [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

    function automatic int mdim(int m, int y);
        if (m < 1 || m > 12) return 0;
        return dim_tbl[m-1] + ((m == 2 && y % 4 == 0) ? 1 : 0);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp[31:0]) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sod = 0; m_day = 1; m_mon = 1; m_year = 0;
        m_sp = 0; m_dp = 0; m_cp = 0; m_err = 0; m_tq = 0; m_armed = 0;
    endtask

    task automatic model_step();
        bit tk;
        tk = m_armed && (sec_toggle != m_tq);
        m_tq = sec_toggle;
        m_armed = 1;
        m_sp = 0; m_dp = 0; m_cp = 0; m_err = 0;
        if (set_en) begin
            if (set_sec < 60 && set_min < 60 && set_hour < 24 && set_year < 100 &&
                set_day >= 1 && int'(set_day) <= mdim(set_month, set_year)) begin
                m_sod = set_hour * 3600 + set_min * 60 + set_sec;
                m_day = set_day; m_mon = set_month; m_year = set_year;
            end else begin
                m_err = 1;
            end
        end else if (tk) begin
            m_sp = 1;
            m_sod++;
            if (m_sod == 86400) begin
                m_sod = 0;
                m_dp = 1;
                m_day++;
                if (m_day > mdim(m_mon, m_year)) begin
                    m_day = 1;
                    m_mon++;
                    if (m_mon > 12) begin
                        m_mon = 1;
                        m_year++;
                        if (m_year > 99) begin
                            m_year = 0;
                            m_cp = 1;
                        end
                    end
                end
            end
        end
    endtask

    always @(negedge clk_in) begin
        if (!rst_n) model_reset();
        cmp("m_sec",     sec,           m_sod % 60);
        cmp("m_min",     min,           (m_sod / 60) % 60);
        cmp("m_hour",    hour,          m_sod / 3600);
        cmp("m_day",     day,           m_day);
        cmp("m_month",   month,         m_mon);
        cmp("m_year",    year,          m_year);
        cmp("m_sec_pulse", sec_pulse,   m_sp);
        cmp("m_day_pulse", day_pulse,   m_dp);
        cmp("m_century",   century_pulse, m_cp);
        cmp("m_set_err",   set_err,     m_err);
        if (rst_n) model_step();
    end

    // Inputs change 1 time unit after the rising edge; checks land just after the edge that consumed them.
    task automatic toggle_once();
        @(posedge clk_in); #1;
        sec_toggle = ~sec_toggle;
        @(posedge clk_in); #1;
    endtask

    task automatic load(input int y, input int mo, input int d, input int h, input int mi, input int s);
        @(posedge clk_in); #1;
        set_en = 1;
        set_year = 7'(y); set_month = 4'(mo); set_day = 5'(d);
        set_hour = 5'(h); set_min = 6'(mi); set_sec = 6'(s);
        @(posedge clk_in); #1;
        set_en = 0;
    endtask

    initial begin
        int exp_sec [5] = '{57, 58, 59, 0, 1};
        rst_n = 0; sec_toggle = 1; set_en = 0;
        set_sec = 0; set_min = 0; set_hour = 0; set_day = 1; set_month = 1; set_year = 0;
        repeat (5) @(posedge clk_in);
        #1 rst_n = 1;
        repeat (3) @(posedge clk_in);
        #1;
        cmp("rst_sec", sec, 0); cmp("rst_hour", hour, 0); cmp("rst_day", day, 1);
        cmp("rst_month", month, 1); cmp("rst_year", year, 0); cmp("rst_no_pulse", sec_pulse, 0);

        load(23, 5, 17, 12, 34, 56);
        cmp("load_sec", sec, 56); cmp("load_day", day, 17); cmp("load_pulse", sec_pulse, 0);
        for (int i = 0; i < 5; i++) begin
            toggle_once();
            cmp("run_sec", sec, exp_sec[i]);
            cmp("run_pulse", sec_pulse, 1);
            if (i == 3) cmp("run_min35", min, 35);
        end

        load(24, 2, 28, 23, 59, 59);
        toggle_once();
        cmp("leap_day", day, 29); cmp("leap_month", month, 2); cmp("leap_hour", hour, 0);
        cmp("leap_dpulse", day_pulse, 1);
        load(23, 2, 28, 23, 59, 59);
        toggle_once();
        cmp("nonleap_day", day, 1); cmp("nonleap_month", month, 3);

        load(99, 12, 31, 23, 59, 59);
        toggle_once();
        cmp("cent_year", year, 0); cmp("cent_month", month, 1); cmp("cent_day", day, 1);
        cmp("cent_sec", sec, 0); cmp("cent_dpulse", day_pulse, 1); cmp("cent_cpulse", century_pulse, 1);

        load(23, 5, 17, 10, 0, 0);
        load(23, 4, 31, 1, 2, 3);
        cmp("bad_apr31_err", set_err, 1); cmp("bad_apr31_hour", hour, 10); cmp("bad_apr31_month", month, 5);
        load(23, 2, 29, 1, 2, 3);
        cmp("bad_feb29_err", set_err, 1); cmp("bad_feb29_day", day, 17);
        load(23, 5, 17, 1, 2, 60);
        cmp("bad_sec60_err", set_err, 1); cmp("bad_sec60_sec", sec, 0);

        @(posedge clk_in); #1;
        set_en = 1; sec_toggle = ~sec_toggle;
        set_year = 7'd30; set_month = 4'd6; set_day = 5'd15;
        set_hour = 5'd8; set_min = 6'd20; set_sec = 6'd10;
        @(posedge clk_in); #1;
        set_en = 0;
        cmp("coll_sec", sec, 10); cmp("coll_min", min, 20); cmp("coll_pulse", sec_pulse, 0);
        @(posedge clk_in); #1;
        cmp("coll_dropped", sec, 10);

        // Random phase: toggles including back-to-back ones, mixed valid and invalid loads biased to rollovers.
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk_in); #1;
            if ($urandom_range(0, 2) != 0) sec_toggle = ~sec_toggle;
            set_en = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1) begin
                set_sec = 6'd59; set_min = 6'd59; set_hour = 5'd23;
                set_day = 5'($urandom_range(28, 31));
            end else begin
                set_sec = 6'($urandom_range(0, 61)); set_min = 6'($urandom_range(0, 60));
                set_hour = 5'($urandom_range(0, 24)); set_day = 5'($urandom_range(0, 31));
            end
            set_month = 4'($urandom_range(0, 13));
            set_year = ($urandom_range(0, 3) == 0) ? 7'd99 : 7'($urandom_range(0, 100));
        end
        @(posedge clk_in); #1;
        set_en = 0;

        load(40, 7, 4, 5, 6, 7);
        toggle_once();
        toggle_once();
        @(posedge clk_in); #3;
        rst_n = 0;
        #1;
        cmp("async_sec", sec, 0); cmp("async_hour", hour, 0); cmp("async_day", day, 1);
        cmp("async_month", month, 1); cmp("async_year", year, 0);
        @(posedge clk_in); #1;
        rst_n = 1;
        repeat (4) @(posedge clk_in);
        #1;
        cmp("post_rst_sec", sec, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
